ryg_monitor: RTL and testbench
==============================

// Module: ryg_monitor
// PURPOSE
//  Passive receiver/checker for the J/P/C traffic-light outputs of the ryg controller.
//  Samples the three light lines every clock, decodes the active phase, and measures
//  how long each phase lasts. Flags one-hot, ordering (J->P->C->J) and duration violations.
//  Sits beside the controller in system benches and on-chip as a safety watchdog.
// PARAMETERS
//  L      10  base phase length in clk cycles (must match controller)
//  S       3  phase offset in clk cycles; expected lengths J=L+S, P=L-S, C=L+2*S (L>S>=0)
// PORTS
//  clk         in   1   system clock; all state changes on posedge
//  rst         in   1   reset; synchronous, active-high
//  J           in   1   light J (1 = may pass)
//  P           in   1   light P
//  C           in   1   light C
//  phase       out  2   decoded phase: 0 none/unknown, 1 J, 2 P, 3 C
//  phase_cnt   out  12  cycles spent in current phase incl. current one; saturates at 4095
//  locked      out  1   1 once a legal-order transition has been seen since last resync
//  phase_done  out  1   1-cycle pulse: locked phase ended in correct order and exact length
//  err_onehot  out  1   1-cycle pulse: {J,P,C} sampled not exactly one-hot
//  err_order   out  1   1-cycle pulse: phase changed to other than the legal successor
//  err_len     out  1   1-cycle pulse: locked phase too short (at change) or overran
//  err_sticky  out  1   OR of all error pulses since reset
//  cycle_cnt   out  8   count of completed legal C->J transitions while locked; wraps 255->0
// BEHAVIOUR
//  - Reset: rst=1 at a posedge -> all outputs 0, FSM=SYNC. rst mid-phase discards the partial phase.
//  - Latency: inputs sampled at posedge k are reflected on outputs after that same edge (1 reg stage).
//  - Decode: exactly one of J/P/C high -> code 1/2/3; otherwise invalid. exp(1)=L+S, exp(2)=L-S, exp(3)=L+2S.
//  - FSM states SYNC, FIRST, LOCKED:
//    SYNC:   invalid -> stay, phase=0, cnt=0. valid -> FIRST, phase=code, cnt=1.
//    FIRST:  same code -> cnt++ (no length check; start unseen).
//            legal successor -> LOCKED, locked=1, phase=code, cnt=1 (no phase_done, no err_len).
//            other valid code -> err_order, stay FIRST, phase=code, cnt=1.
//    LOCKED: same code -> cnt++ ; when cnt becomes exp+1 -> err_len pulse (once per phase).
//            legal successor -> if old cnt==exp: phase_done; if old cnt<exp: err_len;
//              overrun already flagged -> no second pulse. phase=code, cnt=1.
//              cycle_cnt++ on C->J with no err_len for the ending C phase.
//            illegal successor -> err_order, FIRST, locked=0, phase=code, cnt=1, no length check.
//    Any state, invalid sample -> err_onehot, SYNC, phase=0, cnt=0, locked=0.
//  - Priority at one edge: rst > err_onehot > err_order > err_len/phase_done.
//  - At most one of err_onehot/err_order/err_len pulses per edge; phase_done never with an error.
//  - cnt width 12; saturate, never wrap. cycle_cnt wraps modulo 256 silently.
//  - err_sticky set on any error pulse, cleared only by rst.
// STRUCTURE
//  - Package ryg_pkg: PH_NONE/PH_J/PH_P/PH_C 2-bit codes, FSM state codes, CNT_W=12,
//    function exp_len(phase,L,S) returning expected duration.
//  - Sub-module ryg_phase_decode: combinational {J,P,C} -> {valid, code[1:0]};
//    also used by other light monitors. FSM, counters and error logic live in ryg_monitor.
// TESTING (L=10, S=3: J=13, P=7, C=16)
//  1 Drive from ryg controller, shared rst, 4 rounds -> locked at 1st J->P, phase_done each later
//    edge (P:7, C:16, J:13), cycle_cnt=4 after 4th C->J, err_sticky=0.
//  2 Locked, hold P for 6 cycles then C -> err_len pulse on P->C edge, locked stays 1, no phase_done.
//  3 Locked, hold J for 20 cycles -> err_len single pulse at 14th J cycle; none at J->P edge;
//    phase_cnt=20 before change.
//  4 Locked, J and C high together 1 cycle -> err_onehot, phase=0, locked=0. Then J resumes:
//    FIRST, relock at J->P.
//  5 Locked in J, drive C -> err_order, phase=3, phase_cnt=1, locked=0. C->J then relocks.
//  6 rst=1 for 1 cycle mid C phase (cnt=9) -> next edge all outputs 0, err_sticky cleared.
//    Resync from SYNC.

Source files
------------

// File: rtl/ryg_pkg.sv
// Shared definitions for the J/P/C traffic-light monitors.
//   PH_*        2-bit phase codes: 0 none/unknown, 1 J, 2 P, 3 C
//   ST_*        monitor FSM state codes
//   CNT_W       width of the per-phase cycle counter
//   exp_len()   expected duration of a phase for base length l and offset s
//   next_phase() the legal successor in the J->P->C->J rotation
package ryg_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_J    = 2'd1;
  localparam logic [1:0] PH_P    = 2'd2;
  localparam logic [1:0] PH_C    = 2'd3;

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic [CNT_W-1:0] exp_len(input logic [1:0] phase,
                                               input int        l,
                                               input int        s);
    int len;
    case (phase)
      PH_J:    len = l + s;
      PH_P:    len = l - s;
      PH_C:    len = l + 2 * s;
      default: len = 0;
    endcase
    return len[CNT_W-1:0];
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] phase);
    logic [1:0] nxt;
    case (phase)
      PH_J:    nxt = PH_P;
      PH_P:    nxt = PH_C;
      PH_C:    nxt = PH_J;
      default: nxt = PH_NONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ryg_phase_decode.sv
// Combinational decoder for a three-light group.
//   j, p, c  in   raw light lines (1 = lit)
//   valid    out  1 when exactly one light is lit
//   code     out  PH_J / PH_P / PH_C for the lit light, PH_NONE when not valid
module ryg_phase_decode
  import ryg_pkg::*;
(
  input  logic       j,
  input  logic       p,
  input  logic       c,
  output logic       valid,
  output logic [1:0] code
);

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    valid = 1'b1;
    code  = PH_NONE;
    case ({j, p, c})
      3'b100:  code  = PH_J;
      3'b010:  code  = PH_P;
      3'b001:  code  = PH_C;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ryg_monitor.sv
// Passive checker for the J/P/C outputs of the ryg traffic-light controller.
// Samples the lights every clock, tracks the active phase and its duration,
// and flags one-hot, ordering and length violations.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   J, P, C     in   light lines
//   phase       out  decoded phase (0 none, 1 J, 2 P, 3 C)
//   phase_cnt   out  cycles in current phase including this one, saturating
//   locked      out  a legal-order transition has been seen since last resync
//   phase_done  out  pulse: locked phase ended in order with exact length
//   err_onehot  out  pulse: lights not exactly one-hot
//   err_order   out  pulse: phase changed to other than the legal successor
//   err_len     out  pulse: locked phase ended short, or overran its length
//   err_sticky  out  OR of all error pulses since reset
//   cycle_cnt   out  completed clean C->J transitions while locked, wrapping
module ryg_monitor
  import ryg_pkg::*;
#(
  parameter int L = 10,
  parameter int S = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             J,
  input  logic             P,
  input  logic             C,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             locked,
  output logic             phase_done,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_len,
  output logic             err_sticky,
  output logic [7:0]       cycle_cnt
);

  logic       dec_valid;
  logic [1:0] dec_code;

  ryg_phase_decode u_decode (
    .j     (J),
    .p     (P),
    .c     (C),
    .valid (dec_valid),
    .code  (dec_code)
  );

  logic [1:0]       state_q,      state_d;
  logic [1:0]       phase_q,      phase_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             locked_q,     locked_d;
  // Set once the current locked phase has been reported as overrun, so
  // neither the overrun nor the eventual change raises a second err_len.
  logic             flagged_q,    flagged_d;
  logic             done_q,       done_d;
  logic             onehot_q,     onehot_d;
  logic             order_q,      order_d;
  logic             len_q,        len_d;
  logic             sticky_q,     sticky_d;
  logic [7:0]       cycle_q,      cycle_d;

  logic [CNT_W-1:0] exp_cur;
  logic [CNT_W:0]   exp_plus1;
  logic [CNT_W-1:0] cnt_inc;
  logic             same_phase;
  logic             legal_next;

  always_comb begin
    exp_cur    = exp_len(phase_q, L, S);
    // One bit wider so an expected length at the counter ceiling cannot wrap.
    exp_plus1  = {1'b0, exp_cur} + {{CNT_W{1'b0}}, 1'b1};
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    same_phase = (dec_code == phase_q);
    legal_next = (dec_code == next_phase(phase_q));
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    locked_d  = locked_q;
    flagged_d = flagged_q;
    cycle_d   = cycle_q;
    done_d    = 1'b0;
    onehot_d  = 1'b0;
    order_d   = 1'b0;
    len_d     = 1'b0;

    // A non-one-hot sample outranks everything else and forces a resync.
    if (!dec_valid) begin
      onehot_d  = 1'b1;
      state_d   = ST_SYNC;
      phase_d   = PH_NONE;
      cnt_d     = '0;
      locked_d  = 1'b0;
      flagged_d = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          state_d   = ST_FIRST;
          phase_d   = dec_code;
          cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          flagged_d = 1'b0;
        end

        // The start of this phase was not seen, so its length is unknown.
        ST_FIRST: begin
          if (same_phase) begin
            cnt_d = cnt_inc;
          end else if (legal_next) begin
            state_d   = ST_LOCKED;
            locked_d  = 1'b1;
            phase_d   = dec_code;
            cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
            flagged_d = 1'b0;
          end else begin
            order_d = 1'b1;
            phase_d = dec_code;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        ST_LOCKED: begin
          if (same_phase) begin
            cnt_d = cnt_inc;
            if (({1'b0, cnt_inc} == exp_plus1) && !flagged_q) begin
              len_d     = 1'b1;
              flagged_d = 1'b1;
            end
          end else if (legal_next) begin
            if (!flagged_q) begin
              if (cnt_q == exp_cur) begin
                done_d = 1'b1;
                if (phase_q == PH_C) begin
                  cycle_d = cycle_q + 8'd1;
                end
              end else begin
                // Not flagged and not equal means the phase ended short.
                len_d = 1'b1;
              end
            end
            phase_d   = dec_code;
            cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
            flagged_d = 1'b0;
          end else begin
            order_d   = 1'b1;
            state_d   = ST_FIRST;
            locked_d  = 1'b0;
            phase_d   = dec_code;
            cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
            flagged_d = 1'b0;
          end
        end

        default: begin
          state_d   = ST_SYNC;
          phase_d   = PH_NONE;
          cnt_d     = '0;
          locked_d  = 1'b0;
          flagged_d = 1'b0;
        end
      endcase
    end

    sticky_d = sticky_q | onehot_d | order_d | len_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SYNC;
      phase_q   <= PH_NONE;
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      flagged_q <= 1'b0;
      done_q    <= 1'b0;
      onehot_q  <= 1'b0;
      order_q   <= 1'b0;
      len_q     <= 1'b0;
      sticky_q  <= 1'b0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
      flagged_q <= flagged_d;
      done_q    <= done_d;
      onehot_q  <= onehot_d;
      order_q   <= order_d;
      len_q     <= len_d;
      sticky_q  <= sticky_d;
      cycle_q   <= cycle_d;
    end
  end

  assign phase      = phase_q;
  assign phase_cnt  = cnt_q;
  assign locked     = locked_q;
  assign phase_done = done_q;
  assign err_onehot = onehot_q;
  assign err_order  = order_q;
  assign err_len    = len_q;
  assign err_sticky = sticky_q;
  assign cycle_cnt  = cycle_q;

endmodule

// File: tb/tb_ryg_monitor.sv
// Scoreboard bench for ryg_monitor with L=10, S=3 (J=13, P=7, C=16).
module tb_ryg_monitor;
  import ryg_pkg::*;

  localparam int L = 10;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        J = 1'b0, P = 1'b0, C = 1'b0;
  logic [1:0]  phase;
  logic [11:0] phase_cnt;
  logic        locked, phase_done, err_onehot, err_order, err_len, err_sticky;
  logic [7:0]  cycle_cnt;

  always #5 clk = ~clk;

  ryg_monitor #(.L(L), .S(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .J          (J),
    .P          (P),
    .C          (C),
    .phase      (phase),
    .phase_cnt  (phase_cnt),
    .locked     (locked),
    .phase_done (phase_done),
    .err_onehot (err_onehot),
    .err_order  (err_order),
    .err_len    (err_len),
    .err_sticky (err_sticky),
    .cycle_cnt  (cycle_cnt)
  );

  typedef struct packed {
    logic [1:0]  phase;
    logic [11:0] cnt;
    logic        locked, done, eoh, eord, elen, sticky;
    logic [7:0]  cyc;
  } obs_t;

  typedef struct packed {
    int unsigned edge_n;
    obs_t        o;
  } exp_t;

  exp_t        sb_q[$];
  string       name_q[$];
  int unsigned edge_no = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  obs_t        act;

  assign act = {phase, phase_cnt, locked, phase_done, err_onehot, err_order,
                err_len, err_sticky, cycle_cnt};

  always @(posedge clk) edge_no <= edge_no + 1;

  // Monitor: after each edge, compare every expectation tagged for that edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_no) begin
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (e.edge_n != edge_no) begin
        n_bad++;
        $display("FAIL %s: expectation for edge %0d seen at edge %0d", nm, e.edge_n, edge_no);
      end else if (act !== e.o) begin
        n_bad++;
        $display("FAIL %s: got ph=%0d cnt=%0d lk=%b done=%b oh=%b ord=%b len=%b stk=%b cyc=%0d, want ph=%0d cnt=%0d lk=%b done=%b oh=%b ord=%b len=%b stk=%b cyc=%0d",
                 nm, act.phase, act.cnt, act.locked, act.done, act.eoh, act.eord, act.elen,
                 act.sticky, act.cyc, e.o.phase, e.o.cnt, e.o.locked, e.o.done, e.o.eoh,
                 e.o.eord, e.o.elen, e.o.sticky, e.o.cyc);
      end
    end
  end

  // Drive one sample; it is taken at the next posedge.
  task automatic step(input logic j, input logic p, input logic c, input logic r = 1'b0);
    @(negedge clk);
    rst = r;
    J   = j;
    P   = p;
    C   = c;
  endtask

  task automatic hold(input logic j, input logic p, input logic c, input int n);
    for (int i = 0; i < n; i++) step(j, p, c);
  endtask

  // Expected outputs after the edge that samples the most recent step().
  task automatic expect_obs(input string nm, input logic [1:0] ph, input int cnt,
                            input logic lk, input logic dn, input logic oh,
                            input logic od, input logic ln, input logic st,
                            input int cy);
    exp_t e;
    e.edge_n   = edge_no + 1;
    e.o.phase  = ph;
    e.o.cnt    = cnt[11:0];
    e.o.locked = lk;
    e.o.done   = dn;
    e.o.eoh    = oh;
    e.o.eord   = od;
    e.o.elen   = ln;
    e.o.sticky = st;
    e.o.cyc    = cy[7:0];
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with J lit.
    step(1, 0, 0, 1'b1);
    expect_obs("reset", PH_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

    // 1: four clean controller rounds.
    for (int r = 0; r < 4; r++) begin
      step(1, 0, 0);
      if (r == 0) expect_obs("t1_first_j", PH_J, 1, 0, 0, 0, 0, 0, 0, 0);
      else        expect_obs("t1_j_start", PH_J, 1, 1, 1, 0, 0, 0, 0, r);
      hold(1, 0, 0, 12);
      expect_obs("t1_j_end", PH_J, 13, (r != 0), 0, 0, 0, 0, 0, r);
      step(0, 1, 0);
      expect_obs("t1_p_start", PH_P, 1, 1, (r != 0), 0, 0, 0, 0, r);
      hold(0, 1, 0, 6);
      step(0, 0, 1);
      expect_obs("t1_c_start", PH_C, 1, 1, 1, 0, 0, 0, 0, r);
      hold(0, 0, 1, 15);
      expect_obs("t1_c_end", PH_C, 16, 1, 0, 0, 0, 0, 0, r);
    end
    step(1, 0, 0);
    expect_obs("t1_cycle4", PH_J, 1, 1, 1, 0, 0, 0, 0, 4);

    // 3: J held 20 cycles -> single overrun pulse at cycle 14.
    hold(1, 0, 0, 12);
    expect_obs("t3_j13", PH_J, 13, 1, 0, 0, 0, 0, 0, 4);
    step(1, 0, 0);
    expect_obs("t3_overrun", PH_J, 14, 1, 0, 0, 0, 1, 1, 4);
    step(1, 0, 0);
    expect_obs("t3_j15", PH_J, 15, 1, 0, 0, 0, 0, 1, 4);
    hold(1, 0, 0, 5);
    expect_obs("t3_j20", PH_J, 20, 1, 0, 0, 0, 0, 1, 4);
    step(0, 1, 0);
    expect_obs("t3_j_to_p", PH_P, 1, 1, 0, 0, 0, 0, 1, 4);

    // 2: P held 6 cycles -> short.
    hold(0, 1, 0, 5);
    step(0, 0, 1);
    expect_obs("t2_short_p", PH_C, 1, 1, 0, 0, 0, 1, 1, 4);
    hold(0, 0, 1, 15);
    step(1, 0, 0);
    expect_obs("t2_c_to_j", PH_J, 1, 1, 1, 0, 0, 0, 1, 5);

    // 5: J -> C order violation, then C -> J relocks.
    hold(1, 0, 0, 4);
    step(0, 0, 1);
    expect_obs("t5_order", PH_C, 1, 0, 0, 0, 1, 0, 1, 5);
    hold(0, 0, 1, 3);
    expect_obs("t5_first_cnt", PH_C, 4, 0, 0, 0, 0, 0, 1, 5);
    step(1, 0, 0);
    expect_obs("t5_relock", PH_J, 1, 1, 0, 0, 0, 0, 1, 5);

    // 4: J and C together -> one-hot error, resync, relock at J->P.
    hold(1, 0, 0, 2);
    step(1, 0, 1);
    expect_obs("t4_onehot", PH_NONE, 0, 0, 0, 1, 0, 0, 1, 5);
    step(1, 0, 0);
    expect_obs("t4_first", PH_J, 1, 0, 0, 0, 0, 0, 1, 5);
    hold(1, 0, 0, 12);
    step(0, 1, 0);
    expect_obs("t4_relock", PH_P, 1, 1, 0, 0, 0, 0, 1, 5);

    // 6: reset mid C phase at cnt=9, then resync.
    hold(0, 1, 0, 6);
    step(0, 0, 1);
    expect_obs("t6_p_done", PH_C, 1, 1, 1, 0, 0, 0, 1, 5);
    hold(0, 0, 1, 8);
    expect_obs("t6_c9", PH_C, 9, 1, 0, 0, 0, 0, 1, 5);
    step(0, 0, 1, 1'b1);
    expect_obs("t6_reset", PH_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1);
    expect_obs("t6_resync", PH_C, 1, 0, 0, 0, 0, 0, 0, 0);
    hold(0, 0, 1, 15);
    step(1, 0, 0);
    expect_obs("t6_relock", PH_J, 1, 1, 0, 0, 0, 0, 0, 0);

    // All lights dark while locked.
    step(0, 0, 0);
    expect_obs("dark", PH_NONE, 0, 0, 0, 1, 0, 0, 1, 0);

    // Counter saturation in FIRST (no length checking there).
    step(1, 0, 0);
    expect_obs("sat_start", PH_J, 1, 0, 0, 0, 0, 0, 1, 0);
    hold(1, 0, 0, 4099);
    expect_obs("sat_hold", PH_J, 4095, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0);
    expect_obs("sat_relock", PH_P, 1, 1, 0, 0, 0, 0, 1, 0);

    // Drain: bounded wait for the monitor to consume the last expectation.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation never compared", name_q[0]);
      void'(sb_q.pop_front());
      void'(name_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
